// File: rtl/rv_imm_decode_stage_if.sv
// Handshake and data bundle for rv_imm_decode_stage.
// The master modport is the side that feeds instructions in and consumes the
// decoded entries; the slave modport is the decode stage itself.
interface rv_imm_decode_stage_if #(
    parameter int XLEN = 32,
    parameter int PC_W = XLEN
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_ir;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_ir;
    logic [PC_W-1:0] out_pc;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_illegal;

    modport master (
        output in_valid, in_ir, in_pc, out_ready,
        input  in_ready, out_valid, out_ir, out_pc, out_imm, out_fmt, out_illegal
    );

    modport slave (
        input  in_valid, in_ir, in_pc, out_ready,
        output in_ready, out_valid, out_ir, out_pc, out_imm, out_fmt, out_illegal
    );
endinterface

// File: rtl/rv_imm_decode_stage.sv
// rv_imm_decode_stage: registered RISC-V immediate decoder between fetch and
// decode. Each accepted instruction is decoded combinationally (immediate,
// format code, illegal flag), then held in a main output register backed by
// a one-entry skid register so that in_ready can come straight from a flop.
//
// Optional feature macro: RV_IMM_ZICSR_UIMM_EN
//   defined   -> CSRRWI/CSRRSI/CSRRCI give zero-extended IR[19:15], fmt 7
//   undefined -> those opcodes decode as ordinary I-type, fmt 1
module rv_imm_decode_stage #(
    parameter int XLEN = 32,
    parameter int PC_W = XLEN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    rv_imm_decode_stage_if.slave  bus
);

    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;
`ifdef RV_IMM_ZICSR_UIMM_EN
    localparam logic [2:0] FMT_UIMM  = 3'd7;
`endif

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // One pipeline entry: everything that travels to the decode stage.
    typedef struct packed {
        logic [31:0]     ir;
        logic [PC_W-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    // Immediates are built at 64 bits and truncated, which keeps one set of
    // expressions valid for both XLEN settings.
    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic        is_shift_s;
    logic [63:0] imm_i_s;
    logic [63:0] imm_s_s;
    logic [63:0] imm_b_s;
    logic [63:0] imm_u_s;
    logic [63:0] imm_j_s;
    logic [63:0] shamt_xlen_s;
    logic [63:0] shamt_w_s;
    logic [63:0] imm64_s;
    logic [2:0]  fmt_s;
    logic        illegal_s;
    entry_t      dec_s;

    entry_t      main_r;
    entry_t      skid_r;
    logic        out_valid_r;
    logic        skid_valid_r;
    logic        in_ready_r;

    entry_t      main_n_s;
    entry_t      skid_n_s;
    logic        out_valid_n_s;
    logic        skid_valid_n_s;
    logic        accept_s;
    logic        consume_s;

    assign opcode_s     = bus.in_ir[6:0];
    assign funct3_s     = bus.in_ir[14:12];
    assign is_shift_s   = (funct3_s == 3'b001) || (funct3_s == 3'b101);
    assign imm_i_s      = {{52{bus.in_ir[31]}}, bus.in_ir[31:20]};
    assign imm_s_s      = {{52{bus.in_ir[31]}}, bus.in_ir[31:25], bus.in_ir[11:7]};
    assign imm_b_s      = {{52{bus.in_ir[31]}}, bus.in_ir[7], bus.in_ir[30:25],
                           bus.in_ir[11:8], 1'b0};
    assign imm_u_s      = {{32{bus.in_ir[31]}}, bus.in_ir[31:12], 12'h000};
    assign imm_j_s      = {{44{bus.in_ir[31]}}, bus.in_ir[19:12], bus.in_ir[20],
                           bus.in_ir[30:21], 1'b0};
    // RV64 shifts take a 6-bit shamt; RV32 and the *W shifts take 5 bits.
    assign shamt_xlen_s = (XLEN == 64) ? {58'd0, bus.in_ir[25:20]}
                                       : {59'd0, bus.in_ir[24:20]};
    assign shamt_w_s    = {59'd0, bus.in_ir[24:20]};

    // Opcode classification: select the immediate form, format and legality.
    always_comb begin
        imm64_s   = 64'd0;
        fmt_s     = FMT_NONE;
        illegal_s = 1'b0;
        case (opcode_s)
            OP_LOAD, OP_JALR: begin
                imm64_s = imm_i_s;
                fmt_s   = FMT_I;
            end
            OP_IMM: begin
                if (is_shift_s) begin
                    imm64_s = shamt_xlen_s;
                    fmt_s   = FMT_SHAMT;
                end else begin
                    imm64_s = imm_i_s;
                    fmt_s   = FMT_I;
                end
            end
            OP_STORE: begin
                imm64_s = imm_s_s;
                fmt_s   = FMT_S;
            end
            OP_BRANCH: begin
                imm64_s = imm_b_s;
                fmt_s   = FMT_B;
            end
            OP_LUI, OP_AUIPC: begin
                imm64_s = imm_u_s;
                fmt_s   = FMT_U;
            end
            OP_JAL: begin
                imm64_s = imm_j_s;
                fmt_s   = FMT_J;
            end
            OP_OP: begin
                imm64_s = 64'd0;
                fmt_s   = FMT_NONE;
            end
            OP_IMM32: begin
                if (XLEN != 64) begin
                    illegal_s = 1'b1;
                end else if (is_shift_s) begin
                    imm64_s = shamt_w_s;
                    fmt_s   = FMT_SHAMT;
                end else begin
                    imm64_s = imm_i_s;
                    fmt_s   = FMT_I;
                end
            end
            OP_OP32: begin
                if (XLEN != 64) begin
                    illegal_s = 1'b1;
                end else begin
                    fmt_s = FMT_NONE;
                end
            end
            OP_SYSTEM: begin
`ifdef RV_IMM_ZICSR_UIMM_EN
                if (funct3_s[2] && (funct3_s[1:0] != 2'b00)) begin
                    imm64_s = {59'd0, bus.in_ir[19:15]};
                    fmt_s   = FMT_UIMM;
                end else begin
                    imm64_s = imm_i_s;
                    fmt_s   = FMT_I;
                end
`else
                imm64_s = imm_i_s;
                fmt_s   = FMT_I;
`endif
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase
    end

    assign dec_s = '{ir: bus.in_ir, pc: bus.in_pc, imm: imm64_s[XLEN-1:0],
                     fmt: fmt_s, illegal: illegal_s};

    assign accept_s  = bus.in_valid && in_ready_r;
    assign consume_s = out_valid_r && bus.out_ready;

    // Next state of main/skid: flush wins, then skid drain, then accept, then consume.
    always_comb begin
        main_n_s       = main_r;
        skid_n_s       = skid_r;
        out_valid_n_s  = out_valid_r;
        skid_valid_n_s = skid_valid_r;
        if (flush) begin
            out_valid_n_s  = 1'b0;
            skid_valid_n_s = 1'b0;
        end else if (skid_valid_r) begin
            // in_ready is low here, so no accept can coincide with the drain.
            if (consume_s) begin
                main_n_s       = skid_r;
                out_valid_n_s  = 1'b1;
                skid_valid_n_s = 1'b0;
            end else begin
                main_n_s = main_r;
            end
        end else if (accept_s) begin
            if (!out_valid_r || bus.out_ready) begin
                main_n_s      = dec_s;
                out_valid_n_s = 1'b1;
            end else begin
                skid_n_s       = dec_s;
                skid_valid_n_s = 1'b1;
            end
        end else if (consume_s) begin
            out_valid_n_s = 1'b0;
        end else begin
            out_valid_n_s = out_valid_r;
        end
    end

    // Pipeline registers; in_ready is registered as the inverse of the next skid state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_r       <= '0;
            skid_r       <= '0;
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
        end else begin
            main_r       <= main_n_s;
            skid_r       <= skid_n_s;
            out_valid_r  <= out_valid_n_s;
            skid_valid_r <= skid_valid_n_s;
            in_ready_r   <= !skid_valid_n_s;
        end
    end

    assign bus.in_ready    = in_ready_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_ir      = main_r.ir;
    assign bus.out_pc      = main_r.pc;
    assign bus.out_imm     = main_r.imm;
    assign bus.out_fmt     = main_r.fmt;
    assign bus.out_illegal = main_r.illegal;

endmodule

// File: tb/tb_rv_imm_decode_stage.sv
// Bench for rv_imm_decode_stage: an RV32 and an RV64 instance share the same
// stimulus. A reference queue (at most two entries in flight) predicts
// in_ready, out_valid and the front entry; immediates are computed
// arithmetically from the sign-extended instruction word.
module tb_rv_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_ir = 32'd0;
    logic [63:0] in_pc = 64'd0;

    always #5 clk = ~clk;

    rv_imm_decode_stage_if #(.XLEN(32), .PC_W(32)) b32 ();
    rv_imm_decode_stage_if #(.XLEN(64), .PC_W(64)) b64 ();

    assign b32.in_valid  = in_valid;
    assign b32.in_ir     = in_ir;
    assign b32.in_pc     = in_pc[31:0];
    assign b32.out_ready = out_ready;
    assign b64.in_valid  = in_valid;
    assign b64.in_ir     = in_ir;
    assign b64.in_pc     = in_pc;
    assign b64.out_ready = out_ready;

    rv_imm_decode_stage #(.XLEN(32), .PC_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b32));
    rv_imm_decode_stage #(.XLEN(64), .PC_W(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b64));

    typedef struct {
        logic [31:0] ir;
        logic [63:0] pc;
        logic [63:0] imm32;
        logic [63:0] imm64;
        logic [2:0]  fmt32;
        logic [2:0]  fmt64;
        logic        ill32;
        logic        ill64;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decode straight from the instruction-set immediate layouts.
    function automatic void ref_decode(input logic [31:0] ir, input bit is64,
                                       output logic [63:0] imm, output logic [2:0] fmt,
                                       output logic ill);
        longint sx;
        logic [6:0] op;
        logic [2:0] f3;
        bit sh;
        sx  = $signed(ir);
        op  = ir[6:0];
        f3  = ir[14:12];
        sh  = (f3 == 3'd1) || (f3 == 3'd5);
        imm = 64'd0;
        fmt = 3'd0;
        ill = 1'b0;
        case (op)
            7'h03, 7'h67: begin imm = sx >>> 20; fmt = 3'd1; end
            7'h13: begin
                if (sh) begin imm = is64 ? 64'(ir[25:20]) : 64'(ir[24:20]); fmt = 3'd6; end
                else begin imm = sx >>> 20; fmt = 3'd1; end
            end
            7'h23: begin imm = ((sx >>> 25) <<< 5) + longint'(ir[11:7]); fmt = 3'd2; end
            7'h63: begin
                imm = ((sx >>> 31) <<< 12) + (longint'(ir[7]) << 11)
                    + (longint'(ir[30:25]) << 5) + (longint'(ir[11:8]) << 1);
                fmt = 3'd3;
            end
            7'h37, 7'h17: begin imm = sx & 64'hFFFF_FFFF_FFFF_F000; fmt = 3'd4; end
            7'h6F: begin
                imm = ((sx >>> 31) <<< 20) + (longint'(ir[19:12]) << 12)
                    + (longint'(ir[20]) << 11) + (longint'(ir[30:21]) << 1);
                fmt = 3'd5;
            end
            7'h33: fmt = 3'd0;
            7'h1B: begin
                if (!is64) ill = 1'b1;
                else if (sh) begin imm = 64'(ir[24:20]); fmt = 3'd6; end
                else begin imm = sx >>> 20; fmt = 3'd1; end
            end
            7'h3B: if (!is64) ill = 1'b1;
            7'h73: begin
`ifdef RV_IMM_ZICSR_UIMM_EN
                if (f3 >= 3'd5) begin imm = 64'(ir[19:15]); fmt = 3'd7; end
                else begin imm = sx >>> 20; fmt = 3'd1; end
`else
                imm = sx >>> 20;
                fmt = 3'd1;
`endif
            end
            default: ill = 1'b1;
        endcase
        if (!is64) imm = {32'd0, imm[31:0]};
    endfunction

    task automatic check_outputs();
        chk("in_ready32", 64'(b32.in_ready), 64'(q.size() < 2));
        chk("in_ready64", 64'(b64.in_ready), 64'(q.size() < 2));
        chk("out_valid32", 64'(b32.out_valid), 64'(q.size() > 0));
        chk("out_valid64", 64'(b64.out_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            chk("out_ir32", 64'(b32.out_ir), 64'(q[0].ir));
            chk("out_pc32", 64'(b32.out_pc), {32'd0, q[0].pc[31:0]});
            chk("out_imm32", 64'(b32.out_imm), q[0].imm32);
            chk("out_fmt32", 64'(b32.out_fmt), 64'(q[0].fmt32));
            chk("out_ill32", 64'(b32.out_illegal), 64'(q[0].ill32));
            chk("out_ir64", 64'(b64.out_ir), 64'(q[0].ir));
            chk("out_pc64", b64.out_pc, q[0].pc);
            chk("out_imm64", b64.out_imm, q[0].imm64);
            chk("out_fmt64", 64'(b64.out_fmt), 64'(q[0].fmt64));
            chk("out_ill64", 64'(b64.out_illegal), 64'(q[0].ill64));
        end
    endtask

    // One clock: advance the reference queue with the applied inputs, then check.
    task automatic step(output bit acc);
        exp_t e;
        bit   rdy;
        @(posedge clk);
        rdy = (q.size() < 2);
        acc = in_valid && rdy && !flush;
        if (flush) begin
            q.delete();
        end else begin
            if ((q.size() > 0) && out_ready) void'(q.pop_front());
            if (acc) begin
                e.ir = in_ir;
                e.pc = in_pc;
                ref_decode(in_ir, 1'b0, e.imm32, e.fmt32, e.ill32);
                ref_decode(in_ir, 1'b1, e.imm64, e.fmt64, e.ill64);
                q.push_back(e);
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic send(input logic [31:0] ir, output bit acc);
        in_valid = 1'b1;
        in_ir    = ir;
        in_pc    = {$urandom, $urandom};
        step(acc);
    endtask

    logic [6:0] ops [14] = '{7'h03, 7'h67, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17,
                             7'h6F, 7'h33, 7'h1B, 7'h3B, 7'h73, 7'h7F, 7'h0B};

    initial begin
        bit acc;
        logic [31:0] r;
        logic [31:0] first_ir;
        int budget;

        // Reset values while rst_n is low.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(b32.out_valid), 64'd0);
        chk("rst_imm64", b64.out_imm, 64'd0);
        chk("rst_ir", 64'(b32.out_ir), 64'd0);
        chk("rst_pc64", b64.out_pc, 64'd0);
        chk("rst_fmt", 64'(b32.out_fmt), 64'd0);
        chk("rst_ill", 64'(b64.out_illegal), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(acc);

        // ADDI x1, x0, -1
        out_ready = 1'b1;
        send(32'hFFF00093, acc);
        chk("addi_valid", 64'(b32.out_valid), 64'd1);
        chk("addi_imm32", 64'(b32.out_imm), 64'hFFFF_FFFF);
        chk("addi_imm64", b64.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_fmt", 64'(b32.out_fmt), 64'd1);
        chk("addi_ill", 64'(b32.out_illegal), 64'd0);

        // Back-to-back stream SW, LUI, SRAI: one result per cycle.
        send(32'hFE20AE23, acc);
        chk("sw_imm", 64'(b32.out_imm), 64'hFFFF_FFFC);
        chk("sw_fmt", 64'(b32.out_fmt), 64'd2);
        send(32'h123452B7, acc);
        chk("lui_imm", 64'(b32.out_imm), 64'h1234_5000);
        chk("lui_fmt", 64'(b32.out_fmt), 64'd4);
        send(32'h4030D093, acc);
        chk("srai_imm", 64'(b32.out_imm), 64'h3);
        chk("srai_fmt", 64'(b32.out_fmt), 64'd6);

        // Unknown opcode passes through flagged illegal.
        send(32'h0000007F, acc);
        chk("bad_ill64", 64'(b64.out_illegal), 64'd1);
        chk("bad_imm64", b64.out_imm, 64'd0);

        // CSRRWI with uimm 19.
        send(32'h3009D073, acc);
`ifdef RV_IMM_ZICSR_UIMM_EN
        chk("csr_imm", 64'(b32.out_imm), 64'h13);
        chk("csr_fmt", 64'(b32.out_fmt), 64'd7);
`else
        chk("csr_imm", 64'(b32.out_imm), 64'h300);
        chk("csr_fmt", 64'(b32.out_fmt), 64'd1);
`endif
        in_valid = 1'b0;
        step(acc);

        // Backpressure: two entries stored, third held off until release.
        out_ready = 1'b0;
        first_ir  = 32'h00500113;
        send(first_ir, acc);
        send(32'h00A00193, acc);
        chk("bp_ready", 64'(b32.in_ready), 64'd0);
        in_ir = 32'h0080026F;
        step(acc);
        chk("bp_third_held", 64'(acc), 64'd0);
        step(acc);
        chk("bp_hold_ir", 64'(b32.out_ir), 64'(first_ir));
        out_ready = 1'b1;
        budget = 10;
        acc = 1'b0;
        while (!acc && budget > 0) begin
            step(acc);
            budget--;
        end
        chk("bp_third_accepted", 64'(acc), 64'd1);
        in_valid = 1'b0;
        repeat (4) step(acc);

        // Flush with main and skid full plus an input in flight.
        out_ready = 1'b0;
        send(32'h00100093, acc);
        send(32'h00200093, acc);
        in_ir = 32'h00300093;
        flush = 1'b1;
        step(acc);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 64'(b32.out_valid), 64'd0);
        chk("flush_ready", 64'(b32.in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (4) step(acc);

        // Asynchronous reset in the middle of a transfer.
        out_ready = 1'b0;
        send(32'hFFF00093, acc);
        send(32'h123452B7, acc);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        check_outputs();
        chk("rst2_imm", 64'(b32.out_imm), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(acc);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            r         = $urandom;
            if ($urandom_range(0, 3) != 0) in_ir = {r[31:7], ops[$urandom_range(0, 13)]};
            else in_ir = r;
            in_pc = {$urandom, $urandom};
            step(acc);
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (3) step(acc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_imm_decode_stage.md
Name: rv_imm_decode_stage

Overview:
- Registered, parametrised successor to the combinational immediate generator.
- Sits between fetch and decode; for each instruction, latches the IR and PC and outputs:
  - the fully extended immediate;
  - a format code;
  - an illegal-opcode flag.
- Supports XLEN 32/64, masks shift amounts correctly, and adds a valid/ready pipeline handshake with a 2-entry skid buffer and flush.

Parameters:
- XLEN, 32, immediate/PC width; legal values 32 or 64.
- PC_W, XLEN, width of the PC side-band carried with each instruction.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept an instruction.
- in_ir  in  32  instruction word.
- in_pc  in  PC_W  instruction PC.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts.
- out_ir  out  32  registered IR.
- out_pc  out  PC_W  registered PC.
- out_imm  out  XLEN  extended immediate.
- out_fmt  out  3  format code: 0 NONE/R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 CSR_UIMM.
- out_illegal  out  1  opcode not recognised.

Behaviour:
- Reset: asynchronous on rst_n low. All of the following clear to 0:
  - out_valid, out_imm, out_ir, out_pc, out_fmt, out_illegal;
  - the skid entry and its valid bit.
  - in_ready is 1 once rst_n is high.
- Immediate decode is a combinational function of in_ir, registered on accept. All sign extension is from IR[31] to XLEN.
  - LOAD 0000011, JALR 1100111, OP-IMM 0010011: I-type, fmt 1.
  - STORE 0100011: S-type, fmt 2.
  - BRANCH 1100011: B-type, bit0 = 0, fmt 3.
  - LUI 0110111, AUIPC 0010111: {IR[31:12], 12'b0} sign-extended, fmt 4.
  - JAL 1101111: J-type, bit0 = 0, fmt 5.
  - OP 0110011: imm 0, fmt 0.
  - OP-IMM with funct3 001 or 101: zero-extended shamt, fmt 6.
    - XLEN 32 uses IR[24:20].
    - XLEN 64 uses IR[25:20].
  - XLEN 64 only: OP-IMM-32 0011011 decodes as I-type, except shifts use IR[24:20] and set fmt 6. OP-32 0111011 decodes as fmt 0.
  - SYSTEM 1110011: I-type, fmt 1, unless overridden by the optional feature below.
  - Any other opcode, including the *-32 opcodes when XLEN 32: imm 0, fmt 0, out_illegal 1, still passed through. out_illegal is 0 for all recognised opcodes.
- Handshake:
  - Latency 1 cycle from accept to out_valid.
  - Input is accepted when in_valid && in_ready.
  - Output is consumed when out_valid && out_ready.
  - in_ready = !skid_valid, driven from a register.
- Main register loads on an input accept when !out_valid or out_ready.
  - If an input accept occurs while out_valid && !out_ready, the entry goes to skid and in_ready drops the next cycle.
  - When the output is consumed with skid_valid set, skid moves to main and skid_valid clears.
  - Output data is held stable while out_valid && !out_ready.
- Simultaneous consume and accept with skid empty: the new entry replaces main; out_valid stays 1.
- Flush has highest priority over accept and consume. At the next edge, out_valid and skid_valid clear. An instruction accepted in the flush cycle is discarded. Data registers may keep stale values.
- rst_n asserted mid-transfer discards all entries immediately.
- Throughput: 1 instruction/cycle when out_ready is held high.

Optional Feature:
- Macro: RV_IMM_ZICSR_UIMM_EN.
- When defined: SYSTEM opcode with funct3 101/110/111 (CSRRWI/CSRRSI/CSRRCI) gives imm = zero-extended IR[19:15] and fmt 7.
- When undefined: these decode as ordinary I-type, fmt 1, and fmt 7 is never produced.

Test Plan:
- Accept 0xFFF00093 (ADDI) with out_ready=1 → next cycle out_valid=1, out_imm=0xFFFFFFFF, fmt 1, illegal 0.
- Stream 0xFE20AE23 (SW), 0x123452B7 (LUI), 0x4030D093 (SRAI) back-to-back → out_imm sequence and fmt:
  - 0xFFFFFFFC, fmt 2;
  - 0x12345000, fmt 4;
  - 0x00000003, fmt 6;
  - one result per cycle.
- XLEN 64: input 0xFFF00093 → out_imm=0xFFFFFFFFFFFFFFFF. Input 0x0000007F (bad opcode) → illegal 1, imm 0.
- Hold out_ready=0 and offer 3 instructions → first two stored, in_ready=0 on the third. Release out_ready → outputs appear in order, third accepted afterwards, no loss or duplication.
- Assert flush with main and skid full plus an input in flight → next cycle out_valid=0, in_ready=1, and no flushed instruction ever appears.
- With RV_IMM_ZICSR_UIMM_EN, input 0x3009D073 (CSRRWI uimm=19) → imm 0x00000013, fmt 7. Without the macro → imm 0x00000300, fmt 1.
